// File: rtl/dmux16_pkg.sv
// rtl/dmux16_pkg.sv - shared constants for the demux destination queue
package dmux16_pkg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  // Tag polarity matches the upstream demux select
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/dmux16_chan_fifo.sv
// rtl/dmux16_chan_fifo.sv - single destination channel FIFO with zeroed head when empty
module dmux16_chan_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_head_valid,
  output logic [WIDTH-1:0] o_head_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;

  logic             w_do_push;
  logic             w_do_pop;
  logic [CW-1:0]    w_count_nxt;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & r_valid;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  // Storage is not reset; stale words are masked by the valid gate on the head
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head_valid = r_valid;
  assign o_head_data  = r_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count      = r_count;

endmodule

// File: rtl/dmux16_dest_queue.sv
// rtl/dmux16_dest_queue.sv - routes tagged result words into two independent channel FIFOs
module dmux16_dest_queue #(
  parameter  int WIDTH = dmux16_pkg::WIDTH,
  parameter  int DEPTH = dmux16_pkg::DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] I,
  input  logic             SEL,
  output logic             A_VALID,
  input  logic             A_READY,
  output logic [WIDTH-1:0] A,
  output logic             B_VALID,
  input  logic             B_READY,
  output logic [WIDTH-1:0] B,
  output logic [CW-1:0]    A_COUNT,
  output logic [CW-1:0]    B_COUNT
);

  import dmux16_pkg::*;

  logic w_full_a;
  logic w_full_b;
  logic w_accept;
  logic w_push_a;
  logic w_push_b;

  // Readiness only reflects the channel the current tag points at
  assign IN_READY = RST_N & ~((SEL == SEL_B) ? w_full_b : w_full_a);
  assign w_accept = IN_VALID & IN_READY;
  assign w_push_a = w_accept & (SEL == SEL_A);
  assign w_push_b = w_accept & (SEL == SEL_B);

  dmux16_chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_chan_a (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .i_push       (w_push_a),
    .i_push_data  (I),
    .o_full       (w_full_a),
    .i_pop        (A_READY),
    .o_head_valid (A_VALID),
    .o_head_data  (A),
    .o_count      (A_COUNT)
  );

  dmux16_chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_chan_b (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .i_push       (w_push_b),
    .i_push_data  (I),
    .o_full       (w_full_b),
    .i_pop        (B_READY),
    .o_head_valid (B_VALID),
    .o_head_data  (B),
    .o_count      (B_COUNT)
  );

endmodule

// File: doc/dmux16_dest_queue.md
# dmux16_dest_queue

Downstream consumer of the 16-bit demultiplexer stage in the ALU datapath. It accepts a 16-bit result word tagged with the same select bit the demux uses, and queues it into one of two independent destination channels, A or B. Each channel has its own small FIFO and its own valid/ready output handshake. This lets the ALU keep issuing results while a slow destination drains.

## Interface
Parameters:
- WIDTH, 16, data word width
- DEPTH, 2, entries per channel FIFO; power of two, ≥2
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridable)

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RST_N  in  1  synchronous, active-low reset; sampled on rising edge of CLK
- IN_VALID  in  1  input word present
- IN_READY  out  1  stage can accept the input word
- I  in  WIDTH  input data word
- SEL  in  1  destination tag: 0 → channel A, 1 → channel B (same polarity as the demux)
- A_VALID  out  1  channel A head entry valid
- A_READY  in  1  channel A consumer accepts the head
- A  out  WIDTH  channel A head data
- B_VALID  out  1  channel B head entry valid
- B_READY  in  1  channel B consumer accepts the head
- B  out  WIDTH  channel B head data
- A_COUNT  out  CW  channel A occupancy
- B_COUNT  out  CW  channel B occupancy

## Operation
- Push: when IN_VALID & IN_READY at a rising edge, I is written to the tail of the channel selected by SEL. The other channel is untouched.
- IN_READY = RST_N & !full(SEL): it is combinational on SEL and depends only on the selected channel.
  - A full channel blocks input for its own tag only.
  - A full channel does not block traffic to the other channel.
- IN_READY does not depend on IN_VALID.
- Pop: when X_VALID & X_READY at a rising edge, the head of channel X is removed (X ∈ {A, B}).
- X_VALID = (X_COUNT != 0).
- X shows the head entry when valid. X is driven to 0 when the channel is empty, matching the demux zeroing of the unselected output.
- Full channel plus simultaneous pop: a push is refused. Full-ness is evaluated before the pop; there is no same-cycle pass-through when full.
- Non-full channel, push and pop in the same cycle: both occur and the count is unchanged.
- Empty channel, push: the word appears on X the next cycle. There is no combinational bypass from I to X.
- Pointers wrap modulo DEPTH. The count saturates logically at DEPTH because full refuses pushes.
- Ordering is FIFO per channel. There is no ordering guarantee between channels.
- Reset (RST_N=0 at an edge), including mid-operation:
  - pointers and counts are cleared to 0
  - the effect is visible next cycle: A_VALID=B_VALID=0, A=B=0, A_COUNT=B_COUNT=0
  - in-flight entries are discarded
  - IN_READY is 0 in every cycle where RST_N=0
  - storage contents need not be cleared
- Handshake rules: once X_VALID is high it stays high, and X stays stable, until popped. The upstream producer holds I and SEL stable while IN_VALID & !IN_READY.

## Timing
- Latency from input accept to head-of-channel: 1 cycle, when the channel was empty.
- Throughput: 1 push/cycle into a channel, provided the destination drains 1 word/cycle.
- Count update: 1 cycle after the handshake edge.
- All outputs are registered except:
  - IN_READY (combinational on SEL, the count, and RST_N)
  - X (a read mux on a registered pointer and storage)

## Structure
- Shared package dmux16_pkg:
  - WIDTH default 16
  - DEPTH default 2
  - constants SEL_A=1'b0 and SEL_B=1'b1
- One sub-module, dmux16_chan_fifo, instantiated twice (A, B):
  - ports: push, push data, full, pop, head valid, head data (zero when empty), count
- The top level only decodes SEL into two push enables and forms IN_READY.

## Test plan
- Reset, then idle: after RST_N low for 2 cycles, then high → IN_READY=1, A_VALID=B_VALID=0, A=B=16'h0000, both counts 0.
- Single route: push I=16'hBEEF with SEL=0, A_READY=0 → next cycle A=16'hBEEF, A_VALID=1, A_COUNT=1, B_VALID=0, B=0. Then push 16'h1234 with SEL=1 → B=16'h1234 next cycle, A unchanged.
- Full/blocking: A_READY=0, push 16'h0001, 16'h0002 to A → A_COUNT=2.
  - Third SEL=0 word 16'h0003 sees IN_READY=0 and is held.
  - Switching SEL=1 gives IN_READY=1, and B accepts 16'h0003.
  - Raising A_READY pops 16'h0001, then 16'h0002, in order.
- Simultaneous push/pop: A_COUNT=1 (head 16'hAAAA), push 16'hBBBB with A_READY=1 → A_COUNT stays 1, next head 16'hBBBB. At full with A_READY=1, a push is refused that cycle.
- Wrap-around: stream 8 words 16'h0010–16'h0017 to B with B_READY toggling every cycle → output order is exact and there is no loss or duplication across pointer wrap.
- Reset mid-operation: both channels full, assert RST_N=0 for one edge → next cycle both counts 0, VALIDs 0, outputs 0. After release, a fresh push 16'hC0DE to A is the only entry seen.
